// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbitrated write port onto a small register bank
module reg_bank_arbiter #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ack1,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t              state;
  logic [WIDTH-1:0]    bank [DEPTH];
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                sel;
  logic                winner;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_grant;
    else              winner = req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= WRITE;
            busy       <= 1'b1;
            sel        <= winner;
            last_grant <= winner;
            wr_addr    <= winner ? addr1 : addr0;
            wr_data    <= winner ? data1 : data0;
          end
        end
        WRITE: begin
          bank[wr_addr] <= wr_data;
          ack0          <= ~sel;
          ack1          <= sel;
          state         <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed and randomized checks of reg_bank_arbiter against a transaction model
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0, rd_addr = '0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, busy, last_grant;
  logic [3:0] rd_data;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [3:0] mbank [4];
  bit         mlast;
  int         ackseq [$];

  reg_bank_arbiter #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mbank[i] = '0;
    mlast = 1'b1;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1 chk(tag, rd_data, mbank[a]);
    end
  endtask

  task automatic do_write(input bit p, input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    if (p) begin req1 = 1'b1; addr1 = a; data1 = d; end
    else   begin req0 = 1'b1; addr0 = a; data0 = d; end
    @(negedge clk);
    chk("wr_busy_after_e0", busy, 1);
    chk("wr_no_ack_after_e0", {ack1, ack0}, 0);
    @(negedge clk);
    rd_addr = a;
    #1;
    chk("wr_ack_after_e1", {ack1, ack0}, p ? 2 : 1);
    chk("wr_rd_after_e1", rd_data, d);
    chk("wr_last_grant", last_grant, p);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("wr_ack_low_after_e2", {ack1, ack0}, 0);
    chk("wr_idle_after_e2", busy, 0);
    mbank[a] = d;
    mlast = p;
  endtask

  // Requesters hold REQ until they see ACK, drop it that edge, and may re-raise
  // one cycle later. Every ACK is checked against the round-robin rule applied
  // to the request lines present at the grant edge.
  task automatic traffic(input int n0, input int n1, input bit gaps);
    int         left [2];
    bit         rq [2], d1 [2], d2 [2], dropped [2];
    int         waitf [2];
    logic [1:0] ta [2];
    logic [3:0] td [2];
    int         since_ack, budget, p, exp_p;
    bit         first_ack;
    left[0] = n0; left[1] = n1;
    for (int q = 0; q < 2; q++) begin
      rq[q] = 0; d1[q] = 0; d2[q] = 0; waitf[q] = 0;
      ta[q] = '0; td[q] = '0;
    end
    since_ack = 0; budget = 0; first_ack = 1;
    while ((left[0] + left[1] > 0 || rq[0] || rq[1]) && budget < 2000) begin
      @(negedge clk);
      budget++; since_ack++;
      dropped[0] = 0; dropped[1] = 0;
      chk("ack_exclusive", ack0 & ack1, 0);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        exp_p = (d2[0] && d2[1]) ? int'(!mlast) : int'(d2[1]);
        chk("grant_order", p, exp_p);
        chk("ack_only_when_requested", rq[p], 1);
        if (!first_ack) chk("ack_spacing_min3", since_ack >= 3, 1);
        first_ack = 0; since_ack = 0;
        mbank[ta[p]] = td[p];
        mlast = p[0];
        ackseq.push_back(p);
        if (rq[1-p]) begin
          waitf[1-p]++;
          chk("no_starvation", waitf[1-p] <= 1, 1);
        end
        left[p]--; rq[p] = 0; dropped[p] = 1; waitf[p] = 0;
      end
      for (int q = 0; q < 2; q++) begin
        if (!rq[q] && !dropped[q] && left[q] > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          rq[q] = 1; ta[q] = 2'($urandom); td[q] = 4'($urandom); waitf[q] = 0;
        end
      end
      req0 = rq[0]; addr0 = ta[0]; data0 = td[0];
      req1 = rq[1]; addr1 = ta[1]; data1 = td[1];
      rd_addr = 2'($urandom);
      #1 chk("rd_data_track", rd_data, mbank[rd_addr]);
      d2 = d1; d1 = rq;
    end
    chk("traffic_in_budget", budget < 2000, 1);
    @(negedge clk);
    chk("traffic_end_idle", busy, 0);
    chk("traffic_end_no_ack", {ack1, ack0}, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("por_busy", busy, 0);
    chk("por_last_grant", last_grant, 1);
    chk("por_acks", {ack1, ack0}, 0);

    traffic(2, 2, 1);
    apply_reset(2);
    check_bank("reset_bank_zero");
    chk("reset_acks", {ack1, ack0}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_last_grant", last_grant, 1);

    do_write(0, 2'd2, 4'hA);
    check_bank("single_write_bank");

    apply_reset(1);
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd1; data0 = 4'h3;
    req1 = 1'b1; addr1 = 2'd1; data1 = 4'hC;
    @(negedge clk);
    chk("tie_busy", busy, 1);
    @(negedge clk);
    rd_addr = 2'd1;
    #1;
    chk("tie_first_ack", {ack1, ack0}, 2'b01);
    chk("tie_first_data", rd_data, 4'h3);
    req0 = 1'b0;
    @(negedge clk);
    chk("tie_gap_acks", {ack1, ack0}, 0);
    chk("tie_gap_idle", busy, 0);
    @(negedge clk);
    chk("tie_second_busy", busy, 1);
    chk("tie_second_no_ack_yet", {ack1, ack0}, 0);
    @(negedge clk);
    chk("tie_second_ack", {ack1, ack0}, 2'b10);
    chk("tie_final_data", rd_data, 4'hC);
    chk("tie_last_grant", last_grant, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("tie_end_acks", {ack1, ack0}, 0);
    mbank[1] = 4'hC;
    mlast = 1'b1;

    ackseq.delete();
    traffic(3, 3, 0);
    chk("rr_count", ackseq.size(), 6);
    for (int i = 0; i < ackseq.size(); i++) chk("rr_sequence", ackseq[i], i % 2);

    do_write(0, 2'd3, 4'h7);
    @(negedge clk);
    req1 = 1'b1; addr1 = 2'd3; data1 = 4'hF;
    @(negedge clk);
    chk("midrst_granted", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    rd_addr = 2'd3;
    #1;
    chk("midrst_no_ack", {ack1, ack0}, 0);
    chk("midrst_bank3", rd_data, 4'h0);
    chk("midrst_idle", busy, 0);
    chk("midrst_last_grant", last_grant, 1);
    reset = 1'b0; req1 = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_ack_stays_low", {ack1, ack0}, 0);
    check_bank("midrst_bank_clear");

    do_write(0, 2'd0, 4'h5);
    @(negedge clk);
    rd_addr = 2'd0;
    req1 = 1'b1; addr1 = 2'd0; data1 = 4'h9;
    #1 chk("rdw_before_e0", rd_data, 4'h5);
    @(negedge clk);
    chk("rdw_between_e0_e1", rd_data, 4'h5);
    @(negedge clk);
    chk("rdw_after_e1", rd_data, 4'h9);
    chk("rdw_ack1", {ack1, ack0}, 2'b10);
    req1 = 1'b0;
    @(negedge clk);
    mbank[0] = 4'h9;
    mlast = 1'b1;

    repeat (3) traffic(6, 6, 1);
    check_bank("final_bank");
    chk("final_last_grant", last_grant, mlast);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shared 4-entry x 4-bit register bank with one write port, arbitrated between two requesters (port 0, port 1) using round-robin.
- Each requester uses a REQ/ACK handshake. A third consumer reads the bank through an asynchronous read port.
- The block owns the bank storage: D flip-flops with synchronous clear, written only by the arbiter FSM.
- Sits between producer blocks and any consumer of the stored 4-bit words.

Parameters:
- WIDTH, 4, data width of each bank entry
- DEPTH, 4, number of bank entries (power of two)
- ADDR_W, 2, address width, equal to log2(DEPTH)

Ports:
- CLK  input  1  system clock, rising-edge
- RESET  input  1  synchronous, active-high reset
- REQ0  input  1  write request, port 0; held high until ACK0 is seen
- ADDR0  input  ADDR_W  write address, port 0; stable while REQ0 is high
- DATA0  input  WIDTH  write data, port 0; stable while REQ0 is high
- ACK0  output  1  one-cycle write-complete pulse, port 0
- REQ1  input  1  write request, port 1
- ADDR1  input  ADDR_W  write address, port 1
- DATA1  input  WIDTH  write data, port 1
- ACK1  output  1  one-cycle write-complete pulse, port 1
- RD_ADDR  input  ADDR_W  read address
- RD_DATA  output  WIDTH  combinational read of bank[RD_ADDR]
- BUSY  output  1  high whenever FSM is not IDLE
- LAST_GRANT  output  1  index of the most recently granted port

Behaviour:
- Reset: CLK and RESET are the only clock and reset. RESET is synchronous and active-high, sampled on CLK rising edge. While RESET is high at an edge:
  - state goes to IDLE
  - all bank entries go to 0
  - ACK0 and ACK1 go to 0
  - BUSY goes to 0
  - LAST_GRANT goes to 1, so port 0 wins the first tie
- RESET has priority over every other event. An in-flight write (state WRITE) is aborted: the bank is cleared, not written, and no ACK is issued.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If no REQ is high, stay in IDLE.
  - If exactly one REQ is high, grant that port.
  - If both REQ are high, grant the port != LAST_GRANT.
  - On the grant edge: latch the winner's ADDR and DATA into internal registers, set SEL = winner, update LAST_GRANT = winner, go to WRITE.
- WRITE: on the next edge, write bank[latched addr] <= latched data, assert ACK[SEL] = 1, go to ACK.
- ACK: ACK[SEL] is high for exactly this one cycle. On the next edge, ACK goes to 0 and state goes to IDLE. REQ inputs are ignored in WRITE and ACK.
- Timing: with REQ first sampled high at edge E0:
  - bank is updated at E1
  - ACK is high from E1 to E2
  - IDLE is re-entered at E2
  - earliest next grant is at E3 (requester drops REQ at E2)
  - Minimum 3 cycles per write.
- Requester rule: REQ deasserts on the edge where the requester samples ACK high. A REQ still high at E3 is treated as a new request and rewrites the same data.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1. No port waits for more than one foreign write.
- BUSY is registered: high in WRITE and ACK, low in IDLE.
- Read port:
  - RD_DATA = bank[RD_ADDR], purely combinational.
  - A read of the address being written returns the old value until the E1 edge, and the new value after it.
- Width rules: addresses are used modulo DEPTH, no range check. Data is stored unmodified.
- ACK0 and ACK1 are never high in the same cycle.

Test Plan:
- Reset: drive RESET=1 for 2 cycles after arbitrary writes -> RD_DATA=0 for RD_ADDR 0..3; ACK0=ACK1=0, BUSY=0, LAST_GRANT=1.
- Single write: REQ0=1, ADDR0=2, DATA0=4'hA at E0 -> BUSY=1 after E0; bank[2]=A and ACK0=1 after E1; ACK0=0 and BUSY=0 after E2; RD_ADDR=2 gives A.
- Tie after reset: REQ0 and REQ1 both raised in the same cycle (ADDR0=1, DATA0=3; ADDR1=1, DATA1=C) and each held until ACKed -> port 0 ACKed first, port 1 at +3 cycles; final bank[1]=C; LAST_GRANT=1.
- Round-robin under load: both REQ held continuously, each dropping REQ one cycle per ACK, for 6 writes -> ACK sequence 0,1,0,1,0,1; never both ACKs high in one cycle.
- Reset mid-operation: REQ1=1, ADDR1=3, DATA1=F granted at E0, RESET=1 at E1 -> bank[3]=0, ACK1 never asserts, state IDLE, LAST_GRANT=1.
- Read-during-write: RD_ADDR=0 with bank[0]=5, then port 1 writes 9 to address 0 -> RD_DATA=5 through the E0..E1 cycle, 9 immediately after E1.
